seq_sample_feeder: RTL and testbench

- Upstream stage of the running second-largest tracker.
- Accepts sample words over a valid/ready handshake, each word tagged with an end-of-sequence flag, and buffers them in a small FIFO.
- Presents the words one at a time to the tracker.
- After the last word of each sequence has been delivered, emits a one-cycle out_clear pulse. Integration drives the tracker's synchronous resetn from this pulse, so each sequence is ranked independently.

---
 rtl/seq_feeder_pkg.sv | 26 ++
 rtl/seq_fifo.sv | 64 ++++++
 rtl/seq_sample_feeder.sv | 137 +++++++++++++
 tb/tb_seq_sample_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_feeder_pkg.sv
// -----------------------------------------------------------------------------
// seq_feeder_pkg
// Shared types for the sample feeder that sits in front of the running
// second-largest tracker.
//   state_t            : feeder sequencing state (FIRST / MID / CLEAR)
//   entry_t            : FIFO entry layout {data, last} at the default width.
//                        The top module declares the same layout at its
//                        DATA_WIDTH.
//   DEFAULT_DATA_WIDTH : default sample word width
// -----------------------------------------------------------------------------
package seq_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    MID   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } entry_t;

endpackage

// File: rtl/seq_fifo.sv
// -----------------------------------------------------------------------------
// seq_fifo
// Synchronous first-word-fall-through FIFO. Storage is registered, so a word
// written at one edge is visible on o_rd_data from the following cycle.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   i_push, i_wr_data  : write request and word (ignored while full)
//   i_pop              : advance the read pointer (ignored while empty)
//   o_rd_data          : word at the head
//   o_full, o_empty    : occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module seq_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/seq_sample_feeder.sv
// -----------------------------------------------------------------------------
// seq_sample_feeder
// Buffers end-of-sequence-tagged sample words and presents them one at a time
// to the second-largest tracker. After the last word of a sequence is taken,
// one bubble cycle carries an out_clear pulse that resets the tracker.
// Optional feature: define SEQ_SAMPLE_FEEDER_LEN_EN to add output seq_len, the
// saturating word count of the most recently completed sequence.
// Ports:
//   clk, resetn                       : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last : upstream handshake
//   out_valid/out_ready/out_data      : downstream handshake
//   out_first                         : head word opens a sequence
//   out_clear                         : one-cycle downstream clear
//   seq_len (optional)                : length of the last finished sequence
// -----------------------------------------------------------------------------
module seq_sample_feeder
  import seq_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_clear
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
  ,
  output logic [DATA_WIDTH-1:0] seq_len
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } feed_entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_live;
  feed_entry_t w_wr_entry;
  feed_entry_t w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Held low through reset so in_ready rises only after the first edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_live <= 1'b0;
    else         r_live <= 1'b1;
  end

  // Full blocks pushes even when a pop happens in the same cycle.
  assign in_ready   = r_live && !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_wr_entry = '{data: in_data, last: in_last};

  seq_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_wr_data (w_wr_entry),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= FIRST;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FIRST:   if (w_pop) w_state_nxt = w_head.last ? CLEAR : MID;
      MID:     if (w_pop && w_head.last) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = FIRST;
      default: w_state_nxt = FIRST;
    endcase
  end

  // CLEAR is the bubble: nothing is offered while the tracker resets.
  always_comb begin
    out_valid = 1'b0;
    out_first = 1'b0;
    out_clear = 1'b0;
    out_data  = '0;
    case (r_state)
      FIRST: begin
        out_valid = !w_empty;
        out_first = !w_empty;
      end
      MID:     out_valid = !w_empty;
      CLEAR:   out_clear = 1'b1;
      default: ;
    endcase
    if (out_valid) out_data = w_head.data;
  end

`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
  logic [DATA_WIDTH-1:0] r_len_cnt;
  logic [DATA_WIDTH-1:0] r_seq_len;
  logic [DATA_WIDTH-1:0] w_len_nxt;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  assign w_len_nxt = (r_state == FIRST) ? DATA_WIDTH'(1) : sat_inc(r_len_cnt);
  assign seq_len   = r_seq_len;

  // The final count is latched at the last pop, so it is visible in CLEAR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_len_cnt <= '0;
      r_seq_len <= '0;
    end else if (w_pop) begin
      r_len_cnt <= w_len_nxt;
      if (w_head.last) r_seq_len <= w_len_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seq_sample_feeder.sv
module tb_seq_sample_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          out_clear;
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
  logic [DW-1:0] seq_len;
`endif

  seq_sample_feeder #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_clear (out_clear)
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
    ,
    .seq_len   (seq_len)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          first;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic          exp_clear;
  logic          prev_clear;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_first;
  logic          next_first;
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
  logic [DW-1:0] run_len;
  logic [DW-1:0] exp_len;
`endif

  // Scoreboard: inputs and outputs are stable at the falling edge, and what
  // is seen here is what the next rising edge transfers. Pops are checked
  // before this cycle's push is queued, so a same-cycle pass-through shows
  // up as an unexpected word.
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      exp_clear  = 1'b0;
      prev_clear = 1'b0;
      prev_stall = 1'b0;
      next_first = 1'b1;
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
      run_len    = '0;
      exp_len    = '0;
`endif
    end else begin
      chk("clear", 64'(out_clear), 64'(exp_clear));
      if (exp_clear) begin
        chk("clear_vld", 64'(out_valid), 64'(0));
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
        chk("seq_len", 64'(seq_len), 64'(exp_len));
`endif
      end
      if (prev_clear && q.size() > 0) chk("bubble", 64'(out_valid), 64'(1));
      if (prev_stall) begin
        chk("stall_vld", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_first", 64'(out_first), 64'(prev_first));
      end
      if (!out_valid) chk("idle_data", 64'(out_data), 64'(0));
      prev_clear = exp_clear;
      exp_clear  = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_vld", 64'(out_valid), 64'(0));
        end else begin
          mon_e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.data));
          chk("out_first", 64'(out_first), 64'(mon_e.first));
`ifdef SEQ_SAMPLE_FEEDER_LEN_EN
          run_len = mon_e.first ? DW'(1) : run_len + DW'(1);
          if (mon_e.last) exp_len = run_len;
`endif
          if (mon_e.last) exp_clear = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_first = out_first;
      if (in_valid && in_ready) begin
        q.push_back('{data: in_data, last: in_last, first: next_first});
        next_first = in_last;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input logic l);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("push_tmo", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !exp_clear && !prev_clear) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(q.size()), 64'(0));
  endtask

  bit pat [8];

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    #1;
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_vld", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_first", 64'(out_first), 64'(0));
    chk("rst_clr", 64'(out_clear), 64'(0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_rst", 64'(in_ready), 64'(1));

    // Basic sequence 2,6,0,E,C
    out_ready = 1'b1;
    push_word(32'h2, 1'b0);
    push_word(32'h6, 1'b0);
    push_word(32'h0, 1'b0);
    push_word(32'hE, 1'b0);
    push_word(32'hC, 1'b1);
    drain();

    // Fill to full with downstream stalled, then release
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) push_word(DW'(32'h10 + w), 1'b0);
    @(negedge clk);
    chk("full_rdy", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 32'h15;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_rdy", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    push_word(32'h15, 1'b0);
    push_word(32'h16, 1'b0);
    push_word(32'h17, 1'b1);
    drain();

    // Back-to-back sequences {5} {0,1,2}
    push_word(32'h5, 1'b1);
    push_word(32'h0, 1'b0);
    push_word(32'h1, 1'b0);
    push_word(32'h2, 1'b1);
    drain();

    // out_ready toggling mid-sequence
    out_ready = 1'b0;
    push_word(32'h21, 1'b0);
    push_word(32'h22, 1'b0);
    push_word(32'h23, 1'b0);
    push_word(32'h24, 1'b1);
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while in MID with 3 words buffered
    out_ready = 1'b0;
    push_word(32'h31, 1'b0);
    push_word(32'h32, 1'b0);
    push_word(32'h33, 1'b0);
    push_word(32'h34, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    chk("arst_first", 64'(out_first), 64'(0));
    chk("arst_clr", 64'(out_clear), 64'(0));
    chk("arst_rdy", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1 chk("arst_rdy_rel", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    push_word(32'h9, 1'b1);
    drain();

    // Single-word sequences with pushes landing in the CLEAR cycle
    push_word(32'h3, 1'b1);
    push_word(32'h4, 1'b1);
    push_word(32'h5, 1'b1);
    push_word(32'h6, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
